// File: rtl/bottleneck_sram_slave.sv
// bottleneck_sram_slave: 16-bit wait-stated SRAM responder for bottleneck's narrow side.
// Define BOTTLENECK_SRAM_SLAVE_SIGNEXT_EN to sign-extend byte reads when signed_i is set.
module bottleneck_sram_slave #(
   parameter int ADR_WIDTH   = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [63:0] adr_i,
   input  logic        cyc_i,
   input  logic        stb_i,
   input  logic        we_i,
   input  logic        siz_i,
   input  logic        signed_i,
   input  logic [15:0] dat_i,
   output logic        ack_o,
   output logic [15:0] dat_o
);
   typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;
   state_t state;
   logic [3:0] cnt;
   logic [ADR_WIDTH-1:0] lat_adr, f_adr;
   logic lat_we, lat_siz, f_we, f_siz, req, idle, enter_ack, lane;
   logic [15:0] lat_dat, f_dat, word, wr_word, rd_word;
   logic [7:0] sel, ext;
   logic [15:0] mem [2**(ADR_WIDTH-1)];
   logic unused_adr;
   assign unused_adr = &{1'b0, adr_i[63:ADR_WIDTH]};
   assign req   = cyc_i & stb_i;
   assign idle  = state == IDLE;
   // With zero wait states the transfer completes on the acceptance edge, so
   // the live inputs stand in for the not-yet-latched fields.
   assign enter_ack = req & (idle ? (WAIT_STATES == 0) : (state == WAIT && cnt == 4'd0));
   assign f_adr = idle ? adr_i[ADR_WIDTH-1:0] : lat_adr;
   assign f_we  = idle ? we_i : lat_we;
   assign f_siz = idle ? siz_i : lat_siz;
   assign f_dat = idle ? dat_i : lat_dat;
   assign word  = mem[f_adr[ADR_WIDTH-1:1]];
   assign lane  = f_adr[0];
   assign sel   = lane ? word[15:8] : word[7:0];
   assign wr_word = f_siz ? f_dat : lane ? {f_dat[7:0], word[7:0]} : {word[15:8], f_dat[7:0]};
   assign rd_word = f_siz ? word : {ext, sel};
`ifdef BOTTLENECK_SRAM_SLAVE_SIGNEXT_EN
   logic lat_sgn, f_sgn;
   assign f_sgn = idle ? signed_i : lat_sgn;
   assign ext   = {8{f_sgn & sel[7]}};
   always_ff @(posedge clk_i)
      if (idle && req) lat_sgn <= signed_i;
`else
   logic unused_sgn;
   assign unused_sgn = signed_i;
   assign ext = 8'h00;
`endif
   always_ff @(posedge clk_i)
      if (!reset_i && enter_ack && f_we) mem[f_adr[ADR_WIDTH-1:1]] <= wr_word;
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         cnt   <= 4'd0;
         ack_o <= 1'b0;
         dat_o <= 16'h0000;
      end else begin
         ack_o <= enter_ack;
         if (enter_ack && !f_we) dat_o <= rd_word;
         case (state)
            IDLE: if (req) begin
               lat_adr <= adr_i[ADR_WIDTH-1:0];
               lat_we  <= we_i;
               lat_siz <= siz_i;
               lat_dat <= dat_i;
               state   <= (WAIT_STATES == 0) ? ACK : WAIT;
               cnt     <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end
            WAIT: if (!req) state <= IDLE;
                  else if (cnt == 4'd0) state <= ACK;
                  else cnt <= cnt - 4'd1;
            ACK:  state <= HOLD;
            HOLD: if (!req) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bottleneck_sram_slave.sv
// tb_bottleneck_sram_slave: scoreboarded bench over three instances (1, 0 and 3 wait states).
module tb_bottleneck_sram_slave;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [63:0] adr = '0;
   logic we = 1'b0, siz = 1'b0, sgn = 1'b0;
   logic [15:0] din = '0;
   logic [2:0] cyc = '0, stb = '0, ack;
   logic [15:0] dout [3];
   int ws [3] = '{1, 0, 3};
   int vectors = 0, errors = 0;
   logic [15:0] sb [$];
`ifdef BOTTLENECK_SRAM_SLAVE_SIGNEXT_EN
   localparam logic [15:0] SX_AA = 16'hFFAA;
`else
   localparam logic [15:0] SX_AA = 16'h00AA;
`endif
   always #5 clk = ~clk;
   bottleneck_sram_slave #(.ADR_WIDTH(12), .WAIT_STATES(1)) u_ws1 (
      .clk_i(clk), .reset_i(reset), .adr_i(adr), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we),
      .siz_i(siz), .signed_i(sgn), .dat_i(din), .ack_o(ack[0]), .dat_o(dout[0]));
   bottleneck_sram_slave #(.ADR_WIDTH(12), .WAIT_STATES(0)) u_ws0 (
      .clk_i(clk), .reset_i(reset), .adr_i(adr), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we),
      .siz_i(siz), .signed_i(sgn), .dat_i(din), .ack_o(ack[1]), .dat_o(dout[1]));
   bottleneck_sram_slave #(.ADR_WIDTH(12), .WAIT_STATES(3)) u_ws3 (
      .clk_i(clk), .reset_i(reset), .adr_i(adr), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we),
      .siz_i(siz), .signed_i(sgn), .dat_i(din), .ack_o(ack[2]), .dat_o(dout[2]));

   // One complete transfer: checks ack latency, read data from the scoreboard, and no re-ack while stb is held.
   task automatic run_xfer(input int d, input logic w, input logic s, input logic sg,
                           input logic [63:0] a, input logic [15:0] dat, input logic [15:0] expd,
                           input string name);
      int k;
      logic [15:0] e;
      @(negedge clk);
      adr = a; we = w; siz = s; sgn = sg; din = dat; cyc[d] = 1'b1; stb[d] = 1'b1;
      if (!w) sb.push_back(expd);
      k = 0;
      do begin @(negedge clk); k++; end while (!ack[d] && k < 20);
      vectors++;
      if (k != ws[d] + 1) begin
         errors++;
         $display("FAIL %s latency: ack after %0d cycles, expected %0d", name, k, ws[d] + 1);
      end
      if (!w && sb.size() > 0) begin
         e = sb.pop_front();
         vectors++;
         if (dout[d] !== e) begin
            errors++;
            $display("FAIL %s data: got %h, expected %h", name, dout[d], e);
         end
      end
      @(negedge clk);
      vectors++;
      if (ack[d] !== 1'b0) begin
         errors++;
         $display("FAIL %s hold: ack=%b with stb held, expected 0", name, ack[d]);
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         vectors += 2;
         if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b, expected 0", d, ack[d]); end
         if (dout[d] !== 16'h0000) begin errors++; $display("FAIL reset_dat[%0d]: got %h, expected 0000", d, dout[d]); end
      end
      reset = 1'b0;
   endtask

   task automatic test_halfword;
      run_xfer(0, 1, 1, 0, 64'h1112, 16'hAA55, '0, "hw_wr");
      run_xfer(0, 0, 1, 0, 64'h1112, '0, 16'hAA55, "hw_rd");
      run_xfer(0, 0, 1, 0, 64'h0112, '0, 16'hAA55, "hw_alias_rd");
   endtask

   task automatic test_byte_lanes;
      run_xfer(0, 1, 1, 0, 64'h0010, 16'h1234, '0, "lane_hw_wr");
      run_xfer(0, 1, 0, 0, 64'h0011, 16'h00DD, '0, "lane_hi_wr");
      run_xfer(0, 0, 1, 0, 64'h0010, '0, 16'hDD34, "lane_hw_rd");
      run_xfer(0, 0, 0, 0, 64'h0010, '0, 16'h0034, "lane_lo_rd");
      run_xfer(0, 0, 0, 0, 64'h0011, '0, 16'h00DD, "lane_hi_rd");
      run_xfer(0, 1, 0, 0, 64'h0010, 16'hFF77, '0, "lane_lo_wr");
      run_xfer(0, 0, 1, 0, 64'h0010, '0, 16'hDD77, "lane_lo_chk");
   endtask

   task automatic test_signext;
      run_xfer(0, 1, 1, 0, 64'h0040, 16'h55AA, '0, "sx_wr");
      run_xfer(0, 0, 0, 1, 64'h0040, '0, SX_AA, "sx_neg");
      run_xfer(0, 0, 0, 1, 64'h0041, '0, 16'h0055, "sx_pos");
      run_xfer(0, 0, 0, 0, 64'h0040, '0, 16'h00AA, "sx_unsigned");
      run_xfer(0, 0, 1, 1, 64'h0040, '0, 16'h55AA, "sx_halfword");
   endtask

   task automatic test_abort;
      logic seen;
      run_xfer(2, 1, 1, 0, 64'h0020, 16'h1111, '0, "abort_pre_wr");
      run_xfer(2, 0, 1, 0, 64'h0020, '0, 16'h1111, "abort_pre_rd");
      @(negedge clk);
      adr = 64'h0020; we = 1'b1; siz = 1'b1; din = 16'hBEEF; cyc[2] = 1'b1; stb[2] = 1'b1;
      seen = 1'b0;
      @(negedge clk); seen |= ack[2];
      @(negedge clk); seen |= ack[2];
      stb[2] = 1'b0;
      repeat (6) begin @(negedge clk); seen |= ack[2]; end
      cyc[2] = 1'b0;
      vectors += 2;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_ack: ack seen=%b, expected 0", seen); end
      if (dout[2] !== 16'h1111) begin errors++; $display("FAIL abort_dat: got %h, expected 1111", dout[2]); end
      run_xfer(2, 0, 1, 0, 64'h0020, '0, 16'h1111, "abort_post_rd");
   endtask

   task automatic test_reset_mid;
      run_xfer(2, 1, 1, 0, 64'h0030, 16'h7777, '0, "rst_pre_wr");
      @(negedge clk);
      adr = 64'h0030; we = 1'b1; siz = 1'b1; din = 16'hCAFE; cyc[2] = 1'b1; stb[2] = 1'b1;
      @(negedge clk);
      reset = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
      @(negedge clk);
      vectors += 2;
      if (ack[2] !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b, expected 0", ack[2]); end
      if (dout[2] !== 16'h0000) begin errors++; $display("FAIL rst_mid_dat: got %h, expected 0000", dout[2]); end
      reset = 1'b0;
      run_xfer(2, 0, 1, 0, 64'h0030, '0, 16'h7777, "rst_post_rd");
   endtask

   task automatic test_alias_zero_wait;
      run_xfer(1, 1, 1, 0, 64'h4444_3333_2222_1002, 16'h5A5A, '0, "alias_wr");
      run_xfer(1, 0, 1, 0, 64'h0002, '0, 16'h5A5A, "alias_rd");
      run_xfer(1, 0, 0, 0, 64'hFFFF_0003, '0, 16'h005A, "alias_byte_rd");
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++)
         run_xfer(0, 1, 1, 0, 64'h0080 + 64'(2 * i), 16'(16'hC000 + i * 16'h0111), '0, "b2b_wr");
      for (int i = 0; i < 4; i++)
         run_xfer(0, 0, 1, 0, 64'h0080 + 64'(2 * i), '0, 16'(16'hC000 + i * 16'h0111), "b2b_rd");
   endtask

   initial begin
      test_reset;
      test_halfword;
      test_byte_lanes;
      test_signext;
      test_abort;
      test_reset_mid;
      test_alias_zero_wait;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
